// File: rtl/mcc_pkg.sv
// ---------------------------------------------------------------------------
// mcc_pkg
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - opcode constants (IR[31:26])
//   - FSM state encodings (3-bit, legacy-compatible constants)
//   - ALUOp / PCSrc / RegDst codes
//   - ctrl_t: bundle of every datapath control output
//   - small opcode classification helpers
// Optional feature macro used by the importing files: MCC_ILLEGAL_TRAP_EN
// ---------------------------------------------------------------------------
package mcc_pkg;

    localparam int STATE_W = 3;
    localparam int OP_W    = 6;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // FSM states
    localparam logic [STATE_W-1:0] S_IF     = 3'b000;
    localparam logic [STATE_W-1:0] S_ID     = 3'b001;
    localparam logic [STATE_W-1:0] S_EXE_LS = 3'b010;
    localparam logic [STATE_W-1:0] S_MEM    = 3'b011;
    localparam logic [STATE_W-1:0] S_WB_LD  = 3'b100;
    localparam logic [STATE_W-1:0] S_EXE_BR = 3'b101;
    localparam logic [STATE_W-1:0] S_EXE_AL = 3'b110;
    localparam logic [STATE_W-1:0] S_WB_AL  = 3'b111;

    // ALU functions
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // PC source select
    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // Register-file write destination select
    localparam logic [1:0] REGDST_R31 = 2'b00;
    localparam logic [1:0] REGDST_RT  = 2'b01;
    localparam logic [1:0] REGDST_RD  = 2'b10;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] pc_src;
    } ctrl_t;

    // Register-register ALU instructions (write rd)
    function automatic logic op_is_rtype(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_SLL) || (op == OP_SLT);
    endfunction

    // Register-immediate ALU instructions (write rt)
    function automatic logic op_is_imm(input logic [OP_W-1:0] op);
        return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic op_is_alu(input logic [OP_W-1:0] op);
        return op_is_rtype(op) || op_is_imm(op);
    endfunction

    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic op_is_jump(input logic [OP_W-1:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
        return op_is_alu(op) || op_is_mem(op) || op_is_branch(op) ||
               op_is_jump(op) || (op == OP_HALT);
    endfunction

    // ALU function needed by each opcode; address calc uses add,
    // branch compare uses sub.
    function automatic logic [2:0] alu_op_of(input logic [OP_W-1:0] op);
        logic [2:0] f;
        f = ALU_ADD;
        if ((op == OP_SUB) || op_is_branch(op)) f = ALU_SUB;
        if (op == OP_SLL)                       f = ALU_SLL;
        if (op == OP_ORI)                       f = ALU_OR;
        if ((op == OP_AND) || (op == OP_ANDI))  f = ALU_AND;
        if (op == OP_SLT)                       f = ALU_SLT;
        return f;
    endfunction

endpackage

// File: rtl/mcc_next_state.sv
// ---------------------------------------------------------------------------
// mcc_next_state
// Pure combinational next-state function of the multi-cycle control FSM.
// Ports:
//   state      in  3  current FSM state
//   opCode     in  6  opcode of the instruction held in IR
//   next_state out 3  state to load on the next rising clock edge
// Optional feature macro: MCC_ILLEGAL_TRAP_EN (undefined opcode parks in sID
// instead of being treated as a NOP).
// ---------------------------------------------------------------------------
module mcc_next_state
    import mcc_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    opCode,
    output logic [STATE_W-1:0] next_state
);

    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                if (op_is_jump(opCode))        next_state = S_IF;
                else if (opCode == OP_HALT)    next_state = S_ID;
                else if (op_is_branch(opCode)) next_state = S_EXE_BR;
                else if (op_is_mem(opCode))    next_state = S_EXE_LS;
                else if (op_is_alu(opCode))    next_state = S_EXE_AL;
                else begin
`ifdef MCC_ILLEGAL_TRAP_EN
                    next_state = S_ID;
`else
                    next_state = S_IF;
`endif
                end
            end
            S_EXE_AL: next_state = S_WB_AL;
            S_WB_AL:  next_state = S_IF;
            S_EXE_LS: next_state = S_MEM;
            S_MEM:    next_state = (opCode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  next_state = S_IF;
            S_EXE_BR: next_state = S_IF;
            default:  next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/mcc_control_unit.sv
// ---------------------------------------------------------------------------
// mcc_control_unit
// Control unit of a multi-cycle MIPS-subset CPU. A 3-bit FSM steps each
// instruction through IF/ID/EXE/MEM/WB; all outputs are combinational in
// (state, opCode, zero, sign) and forced to 0 while RST is low, so a reset
// mid-instruction removes every write enable at once.
// Ports:
//   CLK in 1 clock (rising edge); RST in 1 async active-low reset
//   opCode in 6 IR[31:26]; zero/sign in 1 ALU status
//   state out 3 current state
//   PCWre IRWre InsMemRW ALUSrcA ALUSrcB ALUOp[3] ExtSel RegWre RegDst[2]
//   WrRegDSrc DBDataSrc mRD mWR PCSrc[2] : datapath enables / selects
//   illegal out 1 sticky undefined-opcode flag
// Optional feature macro: MCC_ILLEGAL_TRAP_EN (illegal flag + park in sID);
// without it an undefined opcode is a NOP and illegal is tied to 0.
// ---------------------------------------------------------------------------
module mcc_control_unit
    import mcc_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [OP_W-1:0]    opCode,
    input  logic               zero,
    input  logic               sign,
    output logic [STATE_W-1:0] state,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               ExtSel,
    output logic               RegWre,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [1:0]         PCSrc,
    output logic               illegal
);

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    ctrl_t              ctrl;
    logic               branch_taken;

    mcc_next_state u_next_state (
        .state      (state_reg),
        .opCode     (opCode),
        .next_state (state_next)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_reg <= S_IF;
        else      state_reg <= state_next;
    end

    assign branch_taken = ((opCode == OP_BEQ)  &&  zero) ||
                          ((opCode == OP_BNE)  && !zero) ||
                          ((opCode == OP_BLTZ) &&  sign);

    // Mux selects follow the opcode in every state (they only matter where
    // the corresponding enable is active); enables are state-specific.
    always_comb begin
        ctrl = '0;
        if (RST) begin
            ctrl.ext_sel      = !((opCode == OP_ANDI) || (opCode == OP_ORI));
            ctrl.alu_src_a    = (opCode == OP_SLL);
            ctrl.alu_src_b    = op_is_imm(opCode) || op_is_mem(opCode);
            ctrl.alu_op       = alu_op_of(opCode);
            ctrl.wr_reg_d_src = (opCode != OP_JAL);
            ctrl.db_data_src  = (opCode == OP_LW);
            if (opCode == OP_JAL)         ctrl.reg_dst = REGDST_R31;
            else if (op_is_rtype(opCode)) ctrl.reg_dst = REGDST_RD;
            else                          ctrl.reg_dst = REGDST_RT;

            case (state_reg)
                S_IF: begin
                    ctrl.ir_wre     = 1'b1;
                    ctrl.ins_mem_rw = 1'b1;
                end
                S_ID: begin
                    if (op_is_jump(opCode)) begin
                        ctrl.pc_wre  = 1'b1;
                        ctrl.pc_src  = (opCode == OP_JR) ? PCSRC_RS : PCSRC_JUMP;
                        ctrl.reg_wre = (opCode == OP_JAL);
                    end else if (!op_is_defined(opCode)) begin
`ifndef MCC_ILLEGAL_TRAP_EN
                        // Undefined opcode retires as a NOP.
                        ctrl.pc_wre = 1'b1;
                        ctrl.pc_src = PCSRC_PC4;
`endif
                    end
                end
                S_MEM: begin
                    if (opCode == OP_SW) begin
                        ctrl.mem_wr = 1'b1;
                        ctrl.pc_wre = 1'b1;
                    end else if (opCode == OP_LW) begin
                        ctrl.mem_rd = 1'b1;
                    end
                end
                S_WB_LD, S_WB_AL: begin
                    ctrl.reg_wre = 1'b1;
                    ctrl.pc_wre  = 1'b1;
                end
                S_EXE_BR: begin
                    ctrl.pc_wre = 1'b1;
                    ctrl.pc_src = branch_taken ? PCSRC_BRANCH : PCSRC_PC4;
                end
                default: ;
            endcase
        end
    end

`ifdef MCC_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            illegal_reg <= 1'b0;
        else if ((state_reg == S_ID) && !op_is_defined(opCode))
            illegal_reg <= 1'b1;
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    assign state     = state_reg;
    assign PCWre     = ctrl.pc_wre;
    assign IRWre     = ctrl.ir_wre;
    assign InsMemRW  = ctrl.ins_mem_rw;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ExtSel    = ctrl.ext_sel;
    assign RegWre    = ctrl.reg_wre;
    assign RegDst    = ctrl.reg_dst;
    assign WrRegDSrc = ctrl.wr_reg_d_src;
    assign DBDataSrc = ctrl.db_data_src;
    assign mRD       = ctrl.mem_rd;
    assign mWR       = ctrl.mem_wr;
    assign PCSrc     = ctrl.pc_src;

endmodule
